prbs_checker: RTL and testbench

PRBS_CHECKER -- requirements
Module: prbs_checker

---
 rtl/prbs_pkg.sv | 32 +++
 rtl/prbs_err_counter.sv | 26 ++
 rtl/prbs_checker.sv | 122 ++++++++++++
 tb/tb_prbs_checker.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS generator/checker pair: FSM state encoding and the
// single LFSR tap table both sides step through.
package prbs_pkg;

  localparam int unsigned LfsrMaxW = 8;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } prbs_state_e;

  // Advance an n-bit Fibonacci LFSR held in the low bits of s; upper bits come back zero.
  function automatic logic [LfsrMaxW-1:0] lfsr_next(input logic [LfsrMaxW-1:0] s,
                                                    input int unsigned n);
    logic                fb;
    logic [LfsrMaxW-1:0] mask;
    case (n)
      2:       fb = s[1] ^ s[0];
      3:       fb = s[2] ^ s[1];
      4:       fb = s[3] ^ s[2];
      5:       fb = s[4] ^ s[2];
      6:       fb = s[5] ^ s[4];
      7:       fb = s[6] ^ s[5];
      8:       fb = s[7] ^ s[5] ^ s[4] ^ s[3];
      default: fb = 1'b0;
    endcase
    mask = 8'hFF >> (LfsrMaxW - n);
    return ((s << 1) & mask) | {7'd0, fb};
  endfunction

endpackage

// File: rtl/prbs_err_counter.sv
// Saturating error counter; a clear wins over a coincident increment.
module prbs_err_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/prbs_checker.sv
// PRBS checker: seeds from the incoming LFSR state, verifies a run of matches, then
// flywheels its own expected sequence and counts mismatches while locked.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [N-1:0]     data_in,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       state_o
);

  localparam int unsigned GoodW = $clog2(LOCK_CNT + 1);
  localparam int unsigned BadW  = $clog2(UNLOCK_CNT + 1);

  prbs_state_e         state_q, state_d;
  logic [LfsrMaxW-1:0] exp_q, exp_d;
  logic [GoodW-1:0]    good_q, good_d;
  logic [BadW-1:0]     bad_q, bad_d;
  logic                locked_q;
  logic                err_pulse_q;
  logic [LfsrMaxW-1:0] din_ext;
  logic [LfsrMaxW-1:0] din_next;
  logic                match;
  logic                err_inc;

  always_comb begin
    din_ext          = '0;
    din_ext[N-1:0]   = data_in;
    din_next         = lfsr_next(din_ext, N);
    match            = (din_ext == exp_q);
    state_d          = state_q;
    exp_d            = exp_q;
    good_d           = good_q;
    bad_d            = bad_q;
    err_inc          = 1'b0;
    if (valid_in) begin
      case (state_q)
        HUNT: begin
          if (din_ext != '0) begin
            exp_d   = din_next;
            good_d  = '0;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (match) begin
            exp_d  = din_next;
            good_d = good_q + 1'b1;
            if (good_q == GoodW'(LOCK_CNT - 1)) begin
              state_d = LOCKED;
              bad_d   = '0;
            end
          end else if (din_ext == '0) begin
            good_d  = '0;
            state_d = HUNT;
          end else begin
            exp_d  = din_next;
            good_d = '0;
          end
        end
        LOCKED: begin
          // Flywheel: once locked the incoming data never reseeds the expectation.
          exp_d = lfsr_next(exp_q, N);
          if (match) begin
            bad_d = '0;
          end else begin
            err_inc = 1'b1;
            bad_d   = bad_q + 1'b1;
            if (bad_q == BadW'(UNLOCK_CNT - 1)) begin
              bad_d   = '0;
              state_d = HUNT;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= HUNT;
      exp_q       <= '0;
      good_q      <= '0;
      bad_q       <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      locked_q    <= (state_d == LOCKED);
      err_pulse_q <= err_inc;
    end
  end

  prbs_err_counter #(
    .CNT_W (CNT_W)
  ) u_err_counter (
    .clk     (clk),
    .reset   (reset),
    .clear_i (clear_cnt),
    .inc_i   (err_inc),
    .count_o (err_count)
  );

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: a default instance and a CNT_W=2 instance share stimulus.
module tb_prbs_checker;

  localparam int unsigned LockCnt   = 4;
  localparam int unsigned UnlockCnt = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_in;
  logic [3:0] data_in;
  logic       clear_cnt;
  logic       locked, err_pulse, locked_s, err_pulse_s;
  logic [15:0] err_count;
  logic [1:0]  err_count_s, state_o, state_s;

  prbs_checker #(
    .N (4), .LOCK_CNT (LockCnt), .UNLOCK_CNT (UnlockCnt), .CNT_W (16)
  ) dut (
    .clk (clk), .reset (reset), .valid_in (valid_in), .data_in (data_in),
    .clear_cnt (clear_cnt), .locked (locked), .err_pulse (err_pulse),
    .err_count (err_count), .state_o (state_o)
  );

  prbs_checker #(
    .N (4), .LOCK_CNT (LockCnt), .UNLOCK_CNT (UnlockCnt), .CNT_W (2)
  ) dut_sat (
    .clk (clk), .reset (reset), .valid_in (valid_in), .data_in (data_in),
    .clear_cnt (clear_cnt), .locked (locked_s), .err_pulse (err_pulse_s),
    .err_count (err_count_s), .state_o (state_s)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [3:0] seq [15] = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101,
                           4'b1010, 4'b0101, 4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100,
                           4'b1000};

  typedef struct packed {
    logic        lk;
    logic        ep;
    logic [15:0] cnt;
    logic [1:0]  cnt_s;
    logic [1:0]  st;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  int         m_state, m_good, m_bad, m_cnt, m_cnt_s;
  logic [3:0] m_exp;
  logic       m_pulse;

  function automatic logic [3:0] nx4(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_state = 0; m_good = 0; m_bad = 0; m_cnt = 0; m_cnt_s = 0;
    m_exp = 4'd0; m_pulse = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [3:0] d, input logic clr);
    logic err;
    err = 1'b0;
    if (v) begin
      case (m_state)
        0: if (d != 4'd0) begin m_exp = nx4(d); m_good = 0; m_state = 1; end
        1: begin
          if (d == m_exp) begin
            m_good++;
            m_exp = nx4(d);
            if (m_good == LockCnt) begin m_state = 2; m_bad = 0; end
          end else if (d == 4'd0) begin
            m_good = 0; m_state = 0;
          end else begin
            m_exp = nx4(d); m_good = 0;
          end
        end
        default: begin
          if (d == m_exp) m_bad = 0;
          else begin
            err = 1'b1;
            m_bad++;
            if (m_bad == UnlockCnt) begin m_bad = 0; m_state = 0; end
          end
          m_exp = nx4(m_exp);
        end
      endcase
    end
    m_pulse = err;
    if (clr) begin
      m_cnt = 0; m_cnt_s = 0;
    end else if (err) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt_s < 3) m_cnt_s++;
    end
  endtask

  task automatic beat(input logic v, input logic [3:0] d, input logic clr);
    exp_t e;
    valid_in = v; data_in = d; clear_cnt = clr;
    model_step(v, d, clr);
    e.lk = (m_state == 2); e.ep = m_pulse; e.cnt = 16'(m_cnt);
    e.cnt_s = 2'(m_cnt_s); e.st = 2'(m_state);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_eq("locked", 32'(locked), 32'(e.lk));
    check_eq("err_pulse", 32'(err_pulse), 32'(e.ep));
    check_eq("err_count", 32'(err_count), 32'(e.cnt));
    check_eq("err_count_sat", 32'(err_count_s), 32'(e.cnt_s));
    check_eq("state_o", 32'(state_o), 32'(e.st));
    valid_in = 1'b0; clear_cnt = 1'b0;
  endtask

  task automatic send_seq(input int start, input int cnt);
    for (int i = 0; i < cnt; i++) beat(1'b1, seq[(start + i) % 15], 1'b0);
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; data_in = 4'd0; clear_cnt = 1'b0;
    model_reset();
    #12;
    check_eq("rst_locked", 32'(locked), 32'd0);
    check_eq("rst_err_pulse", 32'(err_pulse), 32'd0);
    check_eq("rst_err_count", 32'(err_count), 32'd0);
    check_eq("rst_state", 32'(state_o), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Clean lock on the 0011 beat.
    send_seq(0, 4);
    check_eq("lock_early", 32'(locked), 32'd0);
    beat(1'b1, seq[4], 1'b0);
    check_eq("lock_rise", 32'(locked), 32'd1);
    check_eq("lock_cnt0", 32'(err_count), 32'd0);

    // Single error: 0000 in place of 0110.
    beat(1'b1, 4'b0000, 1'b0);
    check_eq("single_pulse", 32'(err_pulse), 32'd1);
    check_eq("single_cnt", 32'(err_count), 32'd1);
    check_eq("single_locked", 32'(locked), 32'd1);
    beat(1'b1, seq[6], 1'b0);
    check_eq("single_pulse_end", 32'(err_pulse), 32'd0);
    check_eq("single_still_locked", 32'(locked), 32'd1);

    // Clear coincident with a mismatch.
    beat(1'b1, seq[7], 1'b0);
    beat(1'b1, 4'b0000, 1'b1);
    check_eq("clr_pulse", 32'(err_pulse), 32'd1);
    check_eq("clr_cnt", 32'(err_count), 32'd0);

    // Loss of lock with three 1111 beats.
    send_seq(9, 3);
    for (int i = 0; i < 3; i++) beat(1'b1, 4'b1111, 1'b0);
    check_eq("unlock_state", 32'(state_o), 32'd0);
    check_eq("unlock_cnt", 32'(err_count), 32'd3);
    check_eq("unlock_locked", 32'(locked), 32'd0);
    send_seq(3, 5);
    check_eq("relock", 32'(locked), 32'd1);

    // Three more errors: the 2-bit counter pins at 3 while the wide one reaches 6.
    for (int i = 0; i < 3; i++) beat(1'b1, 4'b0000, 1'b0);
    check_eq("sat_cnt", 32'(err_count_s), 32'd3);
    check_eq("wide_cnt", 32'(err_count), 32'd6);

    // Lock with idle cycles between valid beats.
    for (int i = 0; i < 5; i++) begin
      beat(1'b0, 4'($urandom), 1'b0);
      check_eq("gap_no_pulse", 32'(err_pulse), 32'd0);
      beat(1'b1, seq[(6 + i) % 15], 1'b0);
      check_eq("gap_lock", 32'(locked), 32'((i == 4) ? 1 : 0));
    end
    beat(1'b0, 4'b0000, 1'b0);
    check_eq("gap_locked_idle_pulse", 32'(err_pulse), 32'd0);

    // Asynchronous reset while locked, well away from any clock edge.
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst_locked", 32'(locked), 32'd0);
    check_eq("async_rst_state", 32'(state_o), 32'd0);
    check_eq("async_rst_cnt", 32'(err_count), 32'd0);
    check_eq("async_rst_cnt_sat", 32'(err_count_s), 32'd0);
    model_reset();
    #2 reset = 1'b0;
    send_seq(10, 5);
    check_eq("reacquire", 32'(locked), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
